elevator_scan_controller: RTL and testbench

Parametrised N-floor elevator car controller that succeeds the fixed 4-floor single-request controller. It latches multiple floor requests into a pending bitmap and serves them in SCAN order: it continues in the current direction while requests lie ahead, then reverses. It models travel time and door-dwell time with counters, and gates departure on door/weight alerts. It sits between the hall/car-call input logic and the motor/door drivers.

---
 rtl/elevator_scan_controller.sv | 144 ++++++++++++++
 tb/tb_elevator_scan_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller: SCAN-order N-floor car controller; ELEV_EMERGENCY_HOME_EN adds emergency homing to floor 0
module elevator_scan_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6,
    parameter int RESET_FLOOR   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ELEV_EMERGENCY_HOME_EN
    input  logic                  emergency,
`endif
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  door_alert,
    input  logic                  weight_alert,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  direction,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending
);
    typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [FLOOR_W:0]   NF     = (FLOOR_W+1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] HOME   = FLOOR_W'(RESET_FLOOR);
    localparam logic [TW-1:0]      T_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      D_LOAD = DW'(DOOR_CYCLES - 1);

    state_t                 state, state_n;
    logic [FLOOR_W-1:0]     floor_n, step_floor;
    logic [NUM_FLOORS-1:0]  pend_n, set_mask, clr_mask, step_mask;
    logic [TW-1:0]          tcnt, tcnt_n;
    logic [DW-1:0]          dcnt, dcnt_n;
    logic                   dir_n, arrived_n, emg, alert, req_ok, same, ahead_up, ahead_dn;

`ifdef ELEV_EMERGENCY_HOME_EN
    assign emg = emergency;
`else
    assign emg = 1'b0;
`endif
    assign alert     = door_alert | weight_alert;
    assign req_ok    = req_valid && !emg && ({1'b0, req_floor} < NF);
    assign same      = req_floor == current_floor;
    assign set_mask  = (req_ok && (state == MOVING || !same)) ? NUM_FLOORS'(1) << req_floor : '0;
    assign moving    = state == MOVING;
    assign door_open = state == DOOR;

    always_comb begin
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            ahead_up |= pending[i] && (FLOOR_W'(i) > current_floor);
            ahead_dn |= pending[i] && (FLOOR_W'(i) < current_floor);
        end
    end

    always_comb begin
        state_n    = state;
        floor_n    = current_floor;
        dir_n      = direction;
        tcnt_n     = tcnt;
        dcnt_n     = dcnt;
        arrived_n  = 1'b0;
        clr_mask   = '0;
        step_floor = direction ? current_floor + 1'b1 : current_floor - 1'b1;
        step_mask  = NUM_FLOORS'(1) << step_floor;
        unique case (state)
            IDLE: begin
                if (req_ok && same) begin
                    state_n = DOOR;
                    dcnt_n  = D_LOAD;
                end else if (emg) begin
                    state_n = current_floor == '0 ? DOOR : MOVING;
                    dir_n   = 1'b0;
                    tcnt_n  = T_LOAD;
                    dcnt_n  = D_LOAD;
                end else if (|pending && !alert) begin
                    state_n = MOVING;
                    dir_n   = direction ? ahead_up : !ahead_dn;
                    tcnt_n  = T_LOAD;
                end
            end
            MOVING: begin
                if (|tcnt) begin
                    tcnt_n = tcnt - 1'b1;
                end else if (direction ? current_floor == TOP : current_floor == '0) begin
                    state_n = IDLE;
                end else begin
                    floor_n = step_floor;
                    if (emg ? step_floor == '0 : |(pending & step_mask)) begin
                        state_n   = DOOR;
                        dcnt_n    = D_LOAD;
                        arrived_n = !emg;
                        clr_mask  = step_mask;
                    end else begin
                        tcnt_n = T_LOAD;
                    end
                    // emergency turns the car around at the next floor and runs it home
                    if (emg) dir_n = 1'b0;
                end
            end
            DOOR: begin
                if (alert || (req_ok && same) || (emg && current_floor == '0)) begin
                    dcnt_n = D_LOAD;
                end else if (|dcnt) begin
                    dcnt_n = dcnt - 1'b1;
                end else if (emg) begin
                    state_n = MOVING;
                    dir_n   = 1'b0;
                    tcnt_n  = T_LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        pend_n = emg ? '0 : (pending | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            current_floor <= HOME;
            direction     <= 1'b1;
            arrived       <= 1'b0;
            pending       <= '0;
            tcnt          <= '0;
            dcnt          <= '0;
        end else begin
            state         <= state_n;
            current_floor <= floor_n;
            direction     <= dir_n;
            arrived       <= arrived_n;
            pending       <= pend_n;
            tcnt          <= tcnt_n;
            dcnt          <= dcnt_n;
        end
    end
endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb_elevator_scan_controller: directed bench for elevator_scan_controller, default build (8 floors, travel 4, door 6)
module tb_elevator_scan_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_floor = 4'd0;
    logic       door_alert = 1'b0;
    logic       weight_alert = 1'b0;
    logic [3:0] current_floor;
    logic       direction, moving, door_open, arrived;
    logic [7:0] pending;
    int         vectors = 0;
    int         miscompares = 0;

    elevator_scan_controller dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
        .door_alert(door_alert), .weight_alert(weight_alert),
        .current_floor(current_floor), .direction(direction), .moving(moving),
        .door_open(door_open), .arrived(arrived), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        go(2);
        rst = 1'b0;
        vectors++; if (current_floor !== 4'd0) begin miscompares++; $display("FAIL reset_floor: got %0d exp 0", current_floor); end
        vectors++; if (direction !== 1'b1) begin miscompares++; $display("FAIL reset_dir: got %b exp 1", direction); end
        vectors++; if ({moving, door_open, arrived} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b exp 000", {moving, door_open, arrived}); end
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL reset_pending: got %h exp 00", pending); end
    endtask

    task automatic test_single_request;
        req_valid = 1'b1; req_floor = 4'd3;
        go(1);
        req_valid = 1'b0;
        vectors++; if (pending !== 8'h08) begin miscompares++; $display("FAIL single_pending: got %h exp 08", pending); end
        vectors++; if (moving !== 1'b0) begin miscompares++; $display("FAIL single_not_yet: got %b exp 0", moving); end
        go(1);
        vectors++; if ({moving, current_floor} !== {1'b1, 4'd0}) begin miscompares++; $display("FAIL single_depart: got %b/%0d exp 1/0", moving, current_floor); end
        go(4);
        vectors++; if (current_floor !== 4'd1) begin miscompares++; $display("FAIL single_step1: got %0d exp 1", current_floor); end
        go(8);
        vectors++; if ({current_floor, arrived, door_open, moving} !== {4'd3, 3'b110}) begin miscompares++; $display("FAIL single_arrive: got %0d/%b%b%b exp 3/110", current_floor, arrived, door_open, moving); end
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL single_clear: got %h exp 00", pending); end
        go(1);
        vectors++; if ({arrived, door_open} !== 2'b01) begin miscompares++; $display("FAIL single_pulse: got %b exp 01", {arrived, door_open}); end
        go(4);
        vectors++; if (door_open !== 1'b1) begin miscompares++; $display("FAIL single_door_last: got %b exp 1", door_open); end
        go(1);
        vectors++; if ({door_open, moving} !== 2'b00) begin miscompares++; $display("FAIL single_door_close: got %b exp 00", {door_open, moving}); end
    endtask

    task automatic test_scan_order;
        rst = 1'b1;
        go(1);
        rst = 1'b0;
        req_valid = 1'b1; req_floor = 4'd3;
        go(1);
        req_valid = 1'b0;
        go(9);
        vectors++; if ({current_floor, moving} !== {4'd2, 1'b1}) begin miscompares++; $display("FAIL scan_at2: got %0d/%b exp 2/1", current_floor, moving); end
        req_valid = 1'b1; req_floor = 4'd5;
        go(1);
        req_floor = 4'd1;
        go(1);
        req_valid = 1'b0;
        vectors++; if (pending !== 8'h2A) begin miscompares++; $display("FAIL scan_pending: got %h exp 2a", pending); end
        go(2);
        vectors++; if ({current_floor, arrived, direction} !== {4'd3, 2'b11}) begin miscompares++; $display("FAIL scan_stop3: got %0d/%b/%b exp 3/1/1", current_floor, arrived, direction); end
        vectors++; if (pending !== 8'h22) begin miscompares++; $display("FAIL scan_pend3: got %h exp 22", pending); end
        go(15);
        vectors++; if ({current_floor, arrived, direction} !== {4'd5, 2'b11}) begin miscompares++; $display("FAIL scan_stop5: got %0d/%b/%b exp 5/1/1", current_floor, arrived, direction); end
        vectors++; if (pending !== 8'h02) begin miscompares++; $display("FAIL scan_pend5: got %h exp 02", pending); end
        go(7);
        vectors++; if ({moving, direction} !== 2'b10) begin miscompares++; $display("FAIL scan_reverse: got %b exp 10", {moving, direction}); end
        go(16);
        vectors++; if ({current_floor, arrived, direction, door_open} !== {4'd1, 3'b101}) begin miscompares++; $display("FAIL scan_stop1: got %0d/%b%b%b exp 1/101", current_floor, arrived, direction, door_open); end
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL scan_pend1: got %h exp 00", pending); end
    endtask

    task automatic test_door_alert;
        int cnt = 0;
        door_alert = 1'b1;
        repeat (10) begin
            go(1);
            cnt += int'(door_open);
        end
        door_alert = 1'b0;
        vectors++; if (cnt !== 10) begin miscompares++; $display("FAIL alert_hold: got %0d open cycles exp 10", cnt); end
        go(5);
        vectors++; if (door_open !== 1'b1) begin miscompares++; $display("FAIL alert_dwell: got %b exp 1", door_open); end
        go(1);
        vectors++; if (door_open !== 1'b0) begin miscompares++; $display("FAIL alert_close: got %b exp 0", door_open); end
    endtask

    task automatic test_weight_alert;
        weight_alert = 1'b1;
        req_valid = 1'b1; req_floor = 4'd0;
        go(1);
        req_valid = 1'b0;
        vectors++; if (pending !== 8'h01) begin miscompares++; $display("FAIL weight_pending: got %h exp 01", pending); end
        go(5);
        vectors++; if (moving !== 1'b0) begin miscompares++; $display("FAIL weight_block: got %b exp 0", moving); end
        weight_alert = 1'b0;
        go(1);
        vectors++; if ({moving, direction} !== 2'b10) begin miscompares++; $display("FAIL weight_depart: got %b exp 10", {moving, direction}); end
        go(4);
        vectors++; if ({current_floor, arrived, pending} !== {4'd0, 1'b1, 8'h00}) begin miscompares++; $display("FAIL weight_arrive: got %0d/%b/%h exp 0/1/00", current_floor, arrived, pending); end
        go(6);
    endtask

    task automatic test_invalid_and_same;
        req_valid = 1'b1; req_floor = 4'd9;
        go(1);
        req_valid = 1'b0;
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL invalid_pending: got %h exp 00", pending); end
        go(1);
        vectors++; if ({moving, door_open} !== 2'b00) begin miscompares++; $display("FAIL invalid_idle: got %b exp 00", {moving, door_open}); end
        req_valid = 1'b1; req_floor = 4'd4;
        go(1);
        req_valid = 1'b0;
        go(17);
        vectors++; if ({current_floor, arrived} !== {4'd4, 1'b1}) begin miscompares++; $display("FAIL same_reach4: got %0d/%b exp 4/1", current_floor, arrived); end
        go(6);
        req_valid = 1'b1; req_floor = 4'd4;
        go(1);
        req_valid = 1'b0;
        vectors++; if ({door_open, moving, pending} !== {2'b10, 8'h00}) begin miscompares++; $display("FAIL same_open: got %b%b/%h exp 10/00", door_open, moving, pending); end
        go(5);
        vectors++; if (door_open !== 1'b1) begin miscompares++; $display("FAIL same_dwell: got %b exp 1", door_open); end
        go(1);
        vectors++; if ({door_open, moving} !== 2'b00) begin miscompares++; $display("FAIL same_close: got %b exp 00", {door_open, moving}); end
    endtask

    task automatic test_simultaneous;
        req_valid = 1'b1; req_floor = 4'd6;
        go(1);
        req_valid = 1'b0;
        vectors++; if (pending !== 8'h40) begin miscompares++; $display("FAIL simul_pending: got %h exp 40", pending); end
        go(8);
        req_valid = 1'b1; req_floor = 4'd6;
        go(1);
        vectors++; if ({current_floor, arrived, pending} !== {4'd6, 1'b1, 8'h00}) begin miscompares++; $display("FAIL simul_same_arrive: got %0d/%b/%h exp 6/1/00", current_floor, arrived, pending); end
        req_floor = 4'd7;
        go(1);
        req_valid = 1'b0;
        vectors++; if ({pending, door_open} !== {8'h80, 1'b1}) begin miscompares++; $display("FAIL simul_door_req: got %h/%b exp 80/1", pending, door_open); end
        go(9);
        req_valid = 1'b1; req_floor = 4'd2;
        go(1);
        req_valid = 1'b0;
        vectors++; if ({current_floor, arrived, pending} !== {4'd7, 1'b1, 8'h04}) begin miscompares++; $display("FAIL simul_other_arrive: got %0d/%b/%h exp 7/1/04", current_floor, arrived, pending); end
    endtask

    task automatic test_async_reset;
        go(23);
        vectors++; if ({current_floor, moving, direction} !== {4'd3, 2'b10}) begin miscompares++; $display("FAIL areset_at3: got %0d/%b%b exp 3/10", current_floor, moving, direction); end
        req_valid = 1'b1; req_floor = 4'd3;
        go(1);
        req_valid = 1'b0;
        vectors++; if (pending !== 8'h0C) begin miscompares++; $display("FAIL areset_moving_req: got %h exp 0c", pending); end
        #2 rst = 1'b1;
        #1;
        vectors++; if ({current_floor, direction, moving, door_open, arrived} !== {4'd0, 4'b1000}) begin miscompares++; $display("FAIL areset_outputs: got %0d/%b%b%b%b exp 0/1000", current_floor, direction, moving, door_open, arrived); end
        vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL areset_pending: got %h exp 00", pending); end
        go(1);
        rst = 1'b0;
        go(2);
        vectors++; if ({current_floor, moving, pending} !== {4'd0, 1'b0, 8'h00}) begin miscompares++; $display("FAIL areset_after: got %0d/%b/%h exp 0/0/00", current_floor, moving, pending); end
    endtask

    initial begin
        test_reset;
        test_single_request;
        test_scan_order;
        test_door_alert;
        test_weight_alert;
        test_invalid_and_same;
        test_simultaneous;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
